// File: rtl/fpu_pkg.sv
// Shared encodings for the FPU issue controller: op codes, FSM states and op latency lookup.
package fpu_pkg;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_MUL = 2'd2;
  localparam logic [1:0] OP_CMP = 2'd3;

  localparam int unsigned CNT_W = 8;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StExec = 2'd1,
    StHold = 2'd2
  } state_e;

  function automatic logic [CNT_W-1:0] op_latency(input logic [1:0]  op,
                                                  input int unsigned lat_addsub,
                                                  input int unsigned lat_mul);
    case (op)
      OP_ADD, OP_SUB: return CNT_W'(lat_addsub);
      OP_MUL:         return CNT_W'(lat_mul);
      default:        return CNT_W'(1);
    endcase
  endfunction

endpackage

// File: rtl/fpu_lat_counter.sv
// Loadable down-counter that paces an FPU operation; saturates at zero.
module fpu_lat_counter
  import fpu_pkg::*;
#(
  parameter int unsigned Width = CNT_W
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  input  logic             dec_i,
  output logic [Width-1:0] count_o
);

  logic [Width-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - Width'(1);
    end
  end

  assign count_o = cnt_q;

endmodule

// File: rtl/fpu_issue_ctrl.sv
// Issues one request at a time to an external FPU, waits out its latency and
// presents the captured result with a valid/ready handshake.
module fpu_issue_ctrl
  import fpu_pkg::*;
#(
  parameter int unsigned LAT_ADDSUB = 3,
  parameter int unsigned LAT_MUL    = 2,
  parameter int unsigned TAG_W      = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [1:0]       req_op_i,
  input  logic [31:0]      req_a_i,
  input  logic [31:0]      req_b_i,
  input  logic [TAG_W-1:0] req_tag_i,
  output logic [31:0]      fpu_a_o,
  output logic [31:0]      fpu_b_o,
  output logic [1:0]       fpu_sel_o,
  input  logic [31:0]      fpu_out_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [31:0]      rsp_data_o,
  output logic [TAG_W-1:0] rsp_tag_o
);

  state_e           state_q;
  logic [31:0]      fpu_a_q;
  logic [31:0]      fpu_b_q;
  logic [1:0]       fpu_sel_q;
  logic [TAG_W-1:0] tag_q;
  logic             rsp_valid_q;
  logic [31:0]      rsp_data_q;

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] load_val;
  logic             accept;
  logic             in_exec;
  logic             exec_done;

  // Ready in HOLD only on the consumer's handshake, so a new op never races the held result.
  always_comb begin
    req_ready_o = 1'b0;
    if (!rst_i) begin
      case (state_q)
        StIdle:  req_ready_o = 1'b1;
        StHold:  req_ready_o = rsp_ready_i;
        default: req_ready_o = 1'b0;
      endcase
    end
  end

  assign accept    = req_valid_i & req_ready_o;
  assign in_exec   = (state_q == StExec);
  assign exec_done = in_exec && (cnt <= CNT_W'(1));
  assign load_val  = op_latency(req_op_i, LAT_ADDSUB, LAT_MUL);

  fpu_lat_counter #(
    .Width(CNT_W)
  ) u_lat_counter (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .load_i    (accept),
    .load_val_i(load_val),
    .dec_i     (in_exec),
    .count_o   (cnt)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      fpu_a_q     <= '0;
      fpu_b_q     <= '0;
      fpu_sel_q   <= '0;
      tag_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      // Operands only move on acceptance; they stay put through EXEC and IDLE.
      if (accept) begin
        fpu_a_q   <= req_a_i;
        fpu_b_q   <= req_b_i;
        fpu_sel_q <= req_op_i;
        tag_q     <= req_tag_i;
      end
      unique case (state_q)
        StIdle: begin
          if (accept) state_q <= StExec;
        end
        StExec: begin
          if (exec_done) begin
            rsp_data_q  <= fpu_out_i;
            rsp_valid_q <= 1'b1;
            state_q     <= StHold;
          end
        end
        StHold: begin
          if (rsp_ready_i) begin
            rsp_valid_q <= 1'b0;
            state_q     <= accept ? StExec : StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign fpu_a_o     = fpu_a_q;
  assign fpu_b_o     = fpu_b_q;
  assign fpu_sel_o   = fpu_sel_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_data_o  = rsp_data_q;
  assign rsp_tag_o   = tag_q;

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Bench for fpu_issue_ctrl: stand-in FPU, timestamp-based reference model, directed and random traffic.
module tb_fpu_issue_ctrl;

  localparam int unsigned LAT_ADDSUB = 3;
  localparam int unsigned LAT_MUL    = 2;
  localparam int unsigned TAG_W      = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             req_valid;
  logic             req_ready;
  logic [1:0]       req_op;
  logic [31:0]      req_a;
  logic [31:0]      req_b;
  logic [TAG_W-1:0] req_tag;
  logic [31:0]      fpu_a;
  logic [31:0]      fpu_b;
  logic [1:0]       fpu_sel;
  logic [31:0]      fpu_out;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [31:0]      rsp_data;
  logic [TAG_W-1:0] rsp_tag;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fpu_issue_ctrl #(
    .LAT_ADDSUB(LAT_ADDSUB),
    .LAT_MUL   (LAT_MUL),
    .TAG_W     (TAG_W)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .req_valid_i(req_valid),
    .req_ready_o(req_ready),
    .req_op_i   (req_op),
    .req_a_i    (req_a),
    .req_b_i    (req_b),
    .req_tag_i  (req_tag),
    .fpu_a_o    (fpu_a),
    .fpu_b_o    (fpu_b),
    .fpu_sel_o  (fpu_sel),
    .fpu_out_i  (fpu_out),
    .rsp_valid_o(rsp_valid),
    .rsp_ready_i(rsp_ready),
    .rsp_data_o (rsp_data),
    .rsp_tag_o  (rsp_tag)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int op_lat(input logic [1:0] op);
    case (op)
      2'd0, 2'd1: return int'(LAT_ADDSUB);
      2'd2:       return int'(LAT_MUL);
      default:    return 1;
    endcase
  endfunction

  // Stand-in FPU: exact IEEE results for the directed vectors, an arbitrary mix otherwise.
  function automatic logic [31:0] fake_fpu(input logic [1:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
    if (op == 2'd0 && a == 32'h3F80_0000 && b == 32'h4000_0000) return 32'h4040_0000;
    if (op == 2'd1 && a == 32'h4040_0000 && b == 32'h3F80_0000) return 32'h4000_0000;
    if (op == 2'd2 && a == 32'h4000_0000 && b == 32'h4040_0000) return 32'h40C0_0000;
    case (op)
      2'd0:    return a + b;
      2'd1:    return a - b;
      2'd2:    return a * b;
      default: return {30'b0, a < b, a == b};
    endcase
  endfunction

  // The FPU output is garbage until its inputs have been stable for the op's latency.
  logic [31:0] last_a, last_b;
  logic [1:0]  last_sel;
  int          stable_q = 0;
  int          stable_now;

  always_comb begin
    stable_now = ((fpu_a === last_a) && (fpu_b === last_b) && (fpu_sel === last_sel)) ?
                 stable_q + 1 : 1;
    fpu_out = (stable_now >= op_lat(fpu_sel)) ? fake_fpu(fpu_sel, fpu_a, fpu_b) : 32'hDEAD_BEEF;
  end

  always @(posedge clk) begin
    last_a   <= fpu_a;
    last_b   <= fpu_b;
    last_sel <= fpu_sel;
    stable_q <= stable_now;
  end

  // Reference model: a request accepted in cycle c has its response visible from cycle c+lat+1.
  int               cyc = 0;
  int               m_due = 0;
  bit               m_inflight = 1'b0;
  bit               m_en = 1'b0;
  logic [31:0]      m_a = '0, m_b = '0, m_data = '0;
  logic [1:0]       m_sel = '0;
  logic [TAG_W-1:0] m_tag = '0;
  logic             exp_rsp_valid;
  logic             exp_req_ready;

  always_comb begin
    exp_rsp_valid = m_inflight && (cyc >= m_due);
    exp_req_ready = !rst && (!m_inflight || (exp_rsp_valid && rsp_ready));
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      m_en       <= 1'b1;
      m_inflight <= 1'b0;
      m_a        <= '0;
      m_b        <= '0;
      m_sel      <= '0;
      m_tag      <= '0;
      m_data     <= '0;
    end else if (exp_req_ready && req_valid) begin
      m_inflight <= 1'b1;
      m_due      <= cyc + op_lat(req_op) + 1;
      m_a        <= req_a;
      m_b        <= req_b;
      m_sel      <= req_op;
      m_tag      <= req_tag;
      m_data     <= fake_fpu(req_op, req_a, req_b);
    end else if (exp_rsp_valid && rsp_ready) begin
      m_inflight <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (m_en) begin
      check("model_req_ready", {31'b0, req_ready}, {31'b0, exp_req_ready});
      check("model_rsp_valid", {31'b0, rsp_valid}, {31'b0, exp_rsp_valid});
      check("model_fpu_a", fpu_a, m_a);
      check("model_fpu_b", fpu_b, m_b);
      check("model_fpu_sel", {30'b0, fpu_sel}, {30'b0, m_sel});
      if (exp_rsp_valid) begin
        check("model_rsp_data", rsp_data, m_data);
        check("model_rsp_tag", 32'(rsp_tag), 32'(m_tag));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called one cycle after the accept edge; n counts cycles from acceptance to rsp_valid.
  task automatic wait_rsp(output int n);
    n = 1;
    @(negedge clk);
    while (!rsp_valid && n < 20) begin
      step();
      n++;
      @(negedge clk);
    end
  endtask

  task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [TAG_W-1:0] tag, output int n);
    req_valid = 1'b1;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    req_tag   = tag;
    step();
    req_valid = 1'b0;
    req_a     = $urandom;
    req_b     = $urandom;
    wait_rsp(n);
  endtask

  task automatic release_rsp();
    step();
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
  endtask

  initial begin
    int n;
    rst       = 1'b1;
    req_valid = 1'b0;
    req_op    = '0;
    req_a     = '0;
    req_b     = '0;
    req_tag   = '0;
    rsp_ready = 1'b0;
    step();
    step();
    @(negedge clk);
    check("rst_req_ready", {31'b0, req_ready}, 32'd0);
    check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("rst_rsp_data", rsp_data, 32'd0);
    check("rst_rsp_tag", 32'(rsp_tag), 32'd0);
    check("rst_fpu_a", fpu_a, 32'd0);
    check("rst_fpu_sel", {30'b0, fpu_sel}, 32'd0);
    step();
    rst = 1'b0;
    @(negedge clk);
    check("rdy_after_rst", {31'b0, req_ready}, 32'd1);
    step();

    do_op(2'd0, 32'h3F80_0000, 32'h4000_0000, 4'd5, n);
    check("add_latency", n, 32'd4);
    check("add_data", rsp_data, 32'h4040_0000);
    check("add_tag", 32'(rsp_tag), 32'd5);
    release_rsp();

    do_op(2'd2, 32'h4000_0000, 32'h4040_0000, 4'd6, n);
    check("mul_latency", n, 32'd3);
    check("mul_data", rsp_data, 32'h40C0_0000);
    release_rsp();

    do_op(2'd3, 32'h3F80_0000, 32'h4000_0000, 4'd9, n);
    check("cmp_latency", n, 32'd2);
    for (int i = 0; i < 10; i++) begin
      step();
      @(negedge clk);
      check("cmp_stall_valid", {31'b0, rsp_valid}, 32'd1);
      check("cmp_stall_data", rsp_data, 32'd2);
      check("cmp_stall_tag", 32'(rsp_tag), 32'd9);
      check("cmp_stall_ready", {31'b0, req_ready}, 32'd0);
    end
    release_rsp();
    @(negedge clk);
    check("cmp_one_hs", {31'b0, rsp_valid}, 32'd0);
    step();

    // Back-to-back SUB then CMP with the request held and the consumer always ready.
    req_valid = 1'b1;
    req_op    = 2'd1;
    req_a     = 32'h4040_0000;
    req_b     = 32'h3F80_0000;
    req_tag   = 4'd3;
    step();
    req_op    = 2'd3;
    req_a     = 32'd1;
    req_b     = 32'd2;
    req_tag   = 4'hA;
    rsp_ready = 1'b1;
    n = 1;
    @(negedge clk);
    while (!(rsp_valid && req_ready) && n < 20) begin
      step();
      n++;
      @(negedge clk);
    end
    check("b2b_sub_latency", n, 32'd4);
    check("b2b_sub_data", rsp_data, 32'h4000_0000);
    check("b2b_sub_tag", 32'(rsp_tag), 32'd3);
    step();
    req_valid = 1'b0;
    n = 1;
    @(negedge clk);
    check("b2b_drop_valid", {31'b0, rsp_valid}, 32'd0);
    while (!rsp_valid && n < 20) begin
      step();
      n++;
      @(negedge clk);
    end
    check("b2b_cmp_latency", n, 32'd2);
    check("b2b_cmp_data", rsp_data, 32'd2);
    check("b2b_cmp_tag", 32'(rsp_tag), 32'hA);
    step();
    rsp_ready = 1'b0;
    step();

    // Reset one cycle into a MUL discards it.
    req_valid = 1'b1;
    req_op    = 2'd2;
    req_a     = 32'h4000_0000;
    req_b     = 32'h4040_0000;
    req_tag   = 4'd2;
    step();
    req_valid = 1'b0;
    rst       = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("rst_mul_no_valid", {31'b0, rsp_valid}, 32'd0);
      step();
    end
    do_op(2'd0, 32'h3F80_0000, 32'h4000_0000, 4'd7, n);
    check("post_rst_latency", n, 32'd4);
    check("post_rst_data", rsp_data, 32'h4040_0000);
    check("post_rst_tag", 32'(rsp_tag), 32'd7);
    release_rsp();

    for (int i = 0; i < 2000; i++) begin
      rst       = ($urandom_range(0, 199) == 0);
      req_valid = $urandom_range(0, 1) == 1;
      req_op    = 2'($urandom_range(0, 3));
      req_a     = $urandom;
      req_b     = $urandom;
      req_tag   = TAG_W'($urandom);
      rsp_ready = $urandom_range(0, 2) != 0;
      step();
    end
    rst       = 1'b0;
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    repeat (8) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
